// File: rtl/stride_seq_pkg.sv
// Shared types for the stride sequence generator.
//   mode_t  : sequence behaviour selected at load time
//   state_t : controller state
//   dir_t   : traversal direction used by BOUNCE mode
package stride_seq_pkg;

   typedef enum logic [1:0] {
      WRAP    = 2'd0,
      BOUNCE  = 2'd1,
      ONESHOT = 2'd2,
      RSVD    = 2'd3
   } mode_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic {
      UP   = 1'b0,
      DOWN = 1'b1
   } dir_t;

endpackage

// File: rtl/stride_next.sv
// Combinational step logic for the stride sequence generator.
// Given the current value, direction and latched configuration, produces the
// value and direction for the next enabled step, plus boundary flags.
//   cur, dir              : present sequence state
//   start, step, limit    : latched configuration
//   mode                  : latched sequence mode (RSVD behaves as WRAP)
//   nxt_cur, nxt_dir      : state after one step
//   over                  : cur+step exceeds limit (carry out counts as over)
//   wrap_evt              : this step is a boundary event
module stride_next
   import stride_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] cur,
   input  dir_t             dir,
   input  logic [WIDTH-1:0] start,
   input  logic [WIDTH-1:0] step,
   input  logic [WIDTH-1:0] limit,
   input  mode_t            mode,
   output logic [WIDTH-1:0] nxt_cur,
   output dir_t             nxt_dir,
   output logic             over,
   output logic             wrap_evt
);

   // One extra bit so a carry out of cur+step or start+step is never lost.
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   floor_sum;
   logic             can_dec;
   logic [WIDTH-1:0] up_val;
   logic [WIDTH-1:0] dn_val;

   assign sum       = {1'b0, cur} + {1'b0, step};
   assign floor_sum = {1'b0, start} + {1'b0, step};
   assign over      = (sum > {1'b0, limit});
   // Stepping down stays at or above start only when cur >= start+step.
   assign can_dec   = ({1'b0, cur} >= floor_sum);
   assign up_val    = sum[WIDTH-1:0];
   assign dn_val    = cur - step;

   always_comb begin
      nxt_cur  = cur;
      nxt_dir  = dir;
      wrap_evt = 1'b0;
      unique case (mode)
         ONESHOT: begin
            if (over) begin
               wrap_evt = 1'b1;
            end else begin
               nxt_cur = up_val;
            end
         end
         BOUNCE: begin
            if (dir == UP) begin
               if (!over) begin
                  nxt_cur = up_val;
               end else begin
                  nxt_dir  = DOWN;
                  wrap_evt = 1'b1;
                  nxt_cur  = can_dec ? dn_val : start;
               end
            end else begin
               if (can_dec) begin
                  nxt_cur = dn_val;
               end else begin
                  nxt_dir  = UP;
                  wrap_evt = 1'b1;
                  nxt_cur  = over ? limit : up_val;
               end
            end
         end
         default: begin
            // WRAP and RSVD
            if (over) begin
               nxt_cur  = start;
               wrap_evt = 1'b1;
            end else begin
               nxt_cur = up_val;
            end
         end
      endcase
   end

endmodule

// File: rtl/stride_seq_gen.sv
// Programmable stride sequence generator.
// A load latches start/step/limit/mode and begins a sequence; each cycle with
// enable high in RUN advances cur by one stride according to the mode.
//   clk, rst_n          : clock, asynchronous active-low reset
//   load                : latch configuration and (re)start; beats enable
//   start_val, step_val : first value and unsigned stride
//   limit_val           : inclusive upper bound
//   mode                : 0 WRAP, 1 BOUNCE, 2 ONESHOT, 3 as WRAP
//   enable              : advance one step per cycle in RUN
//   cur                 : current sequence value (INIT while idle)
//   valid               : high in RUN and DONE
//   wrap                : one-cycle pulse on each boundary event
//   cfg_err             : sticky, last load was rejected
module stride_seq_gen
   import stride_seq_pkg::*;
#(
   parameter int unsigned      WIDTH = 8,
   parameter logic [WIDTH-1:0] INIT  = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] start_val,
   input  logic [WIDTH-1:0] step_val,
   input  logic [WIDTH-1:0] limit_val,
   input  logic [1:0]       mode,
   input  logic             enable,
   output logic [WIDTH-1:0] cur,
   output logic             valid,
   output logic             wrap,
   output logic             cfg_err
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] cur_q, cur_d;
   dir_t             dir_q, dir_d;
   logic             wrap_q, wrap_d;
   logic             valid_q, valid_d;
   logic             cfg_err_q, cfg_err_d;
   logic [WIDTH-1:0] start_q, start_d;
   logic [WIDTH-1:0] step_q, step_d;
   logic [WIDTH-1:0] limit_q, limit_d;
   mode_t            mode_q, mode_d;

   logic             load_ok;
   logic             advance;
   logic [WIDTH-1:0] nxt_cur;
   dir_t             nxt_dir;
   logic             over;
   logic             wrap_evt;

   assign load_ok = (step_val != '0) && (start_val <= limit_val);
   assign advance = (state_q == RUN) && enable;

   stride_next #(
      .WIDTH (WIDTH)
   ) u_next (
      .cur      (cur_q),
      .dir      (dir_q),
      .start    (start_q),
      .step     (step_q),
      .limit    (limit_q),
      .mode     (mode_q),
      .nxt_cur  (nxt_cur),
      .nxt_dir  (nxt_dir),
      .over     (over),
      .wrap_evt (wrap_evt)
   );

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cur_q     <= INIT;
         dir_q     <= UP;
         wrap_q    <= 1'b0;
         valid_q   <= 1'b0;
         cfg_err_q <= 1'b0;
         start_q   <= '0;
         step_q    <= '0;
         limit_q   <= '0;
         mode_q    <= WRAP;
      end else begin
         state_q   <= state_d;
         cur_q     <= cur_d;
         dir_q     <= dir_d;
         wrap_q    <= wrap_d;
         valid_q   <= valid_d;
         cfg_err_q <= cfg_err_d;
         start_q   <= start_d;
         step_q    <= step_d;
         limit_q   <= limit_d;
         mode_q    <= mode_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (load) begin
         state_d = load_ok ? RUN : IDLE;
      end else if (advance && (mode_q == ONESHOT) && over) begin
         state_d = DONE;
      end
   end

   // Output / datapath next values; everything leaves through a register
   always_comb begin
      cur_d     = cur_q;
      dir_d     = dir_q;
      wrap_d    = 1'b0;
      cfg_err_d = cfg_err_q;
      start_d   = start_q;
      step_d    = step_q;
      limit_d   = limit_q;
      mode_d    = mode_q;
      valid_d   = (state_d != IDLE);
      if (load) begin
         dir_d = UP;
         if (load_ok) begin
            start_d   = start_val;
            step_d    = step_val;
            limit_d   = limit_val;
            mode_d    = mode_t'(mode);
            cur_d     = start_val;
            cfg_err_d = 1'b0;
         end else begin
            cur_d     = INIT;
            cfg_err_d = 1'b1;
         end
      end else if (advance) begin
         cur_d  = nxt_cur;
         dir_d  = nxt_dir;
         wrap_d = wrap_evt;
      end
   end

   assign cur     = cur_q;
   assign valid   = valid_q;
   assign wrap    = wrap_q;
   assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_stride_seq_gen.sv
module tb_stride_seq_gen;

   localparam int unsigned W     = 4;
   localparam logic [W-1:0] INITV = 4'd3;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         load;
   logic [W-1:0] start_val, step_val, limit_val;
   logic [1:0]   mode;
   logic         enable;
   logic [W-1:0] cur;
   logic         valid, wrap, cfg_err;

   int n_checks = 0;
   int n_errors = 0;

   stride_seq_gen #(
      .WIDTH (W),
      .INIT  (INITV)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .start_val (start_val),
      .step_val  (step_val),
      .limit_val (limit_val),
      .mode      (mode),
      .enable    (enable),
      .cur       (cur),
      .valid     (valid),
      .wrap      (wrap),
      .cfg_err   (cfg_err)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      bit ld;
      int s, st, lim, md;
      bit en;
      int cur;
      bit v, w, e;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(bit ld, int s, int st, int lim, int md, bit en,
                               int c, bit v, bit w, bit e);
      vec_t t;
      t.ld = ld; t.s = s; t.st = st; t.lim = lim; t.md = md; t.en = en;
      t.cur = c; t.v = v; t.w = w; t.e = e;
      vecs.push_back(t);
   endfunction

   // enable-only step shorthand
   function automatic void en_step(bit en, int c, bit v, bit w, bit e);
      add(0, 0, 0, 0, 0, en, c, v, w, e);
   endfunction

   task automatic check(string name, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_outs(string tag, int c, bit v, bit w, bit e);
      check({tag, "_cur"},     int'(cur),     c);
      check({tag, "_valid"},   int'(valid),   int'(v));
      check({tag, "_wrap"},    int'(wrap),    int'(w));
      check({tag, "_cfg_err"}, int'(cfg_err), int'(e));
   endtask

   task automatic drive(bit ld, int s, int st, int lim, int md, bit en);
      load      = ld;
      start_val = W'(s);
      step_val  = W'(st);
      limit_val = W'(lim);
      mode      = 2'(md);
      enable    = en;
   endtask

   // Behavioural reference: plain integer arithmetic, no width limits, so
   // "over" is simply cur+step > limit.
   int m_state;          // 0 idle, 1 running, 2 finished
   int m_cur, m_err, m_wrap, m_up;
   int m_start, m_step, m_limit, m_mode;

   function automatic void model_reset();
      m_state = 0; m_cur = int'(INITV); m_err = 0; m_wrap = 0; m_up = 1;
      m_start = 0; m_step = 0; m_limit = 0; m_mode = 0;
   endfunction

   function automatic void model_step(bit ld, int s, int st, int lim, int md, bit en);
      int nx, pv;
      bit ov;
      m_wrap = 0;
      if (ld) begin
         m_up = 1;
         if (st == 0 || s > lim) begin
            m_state = 0; m_cur = int'(INITV); m_err = 1;
         end else begin
            m_start = s; m_step = st; m_limit = lim; m_mode = md;
            m_cur = s; m_err = 0; m_state = 1;
         end
      end else if (m_state == 1 && en) begin
         nx = m_cur + m_step;
         pv = m_cur - m_step;
         ov = (nx > m_limit);
         if (m_mode == 2) begin
            if (ov) begin m_state = 2; m_wrap = 1; end
            else m_cur = nx;
         end else if (m_mode == 1) begin
            if (m_up == 1) begin
               if (!ov) m_cur = nx;
               else begin
                  m_up = 0; m_wrap = 1;
                  m_cur = (pv >= m_start) ? pv : m_start;
               end
            end else begin
               if (pv >= m_start) m_cur = pv;
               else begin
                  m_up = 1; m_wrap = 1;
                  m_cur = ov ? m_limit : nx;
               end
            end
         end else begin
            if (ov) begin m_cur = m_start; m_wrap = 1; end
            else m_cur = nx;
         end
      end
   endfunction

   initial begin
      drive(0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;

      // WRAP 0..8 step 2
      add(1, 0, 2, 8, 0, 0,   0, 1, 0, 0);
      en_step(1, 2, 1, 0, 0);
      en_step(1, 4, 1, 0, 0);
      en_step(1, 6, 1, 0, 0);
      en_step(1, 8, 1, 0, 0);
      en_step(1, 0, 1, 1, 0);
      en_step(1, 2, 1, 0, 0);
      // WRAP with carry out of the 4-bit sum
      add(1, 10, 4, 15, 0, 1, 10, 1, 0, 0);
      en_step(1, 14, 1, 0, 0);
      en_step(1, 10, 1, 1, 0);
      en_step(1, 14, 1, 0, 0);
      // BOUNCE
      add(1, 1, 3, 8, 1, 0,   1, 1, 0, 0);
      en_step(1, 4, 1, 0, 0);
      en_step(1, 7, 1, 0, 0);
      en_step(1, 4, 1, 1, 0);
      en_step(0, 4, 1, 0, 0);
      en_step(1, 1, 1, 0, 0);
      en_step(1, 4, 1, 1, 0);
      en_step(1, 7, 1, 0, 0);
      // ONESHOT
      add(1, 0, 2, 8, 2, 0,   0, 1, 0, 0);
      en_step(1, 2, 1, 0, 0);
      en_step(1, 4, 1, 0, 0);
      en_step(1, 6, 1, 0, 0);
      en_step(1, 8, 1, 0, 0);
      en_step(1, 8, 1, 1, 0);
      en_step(1, 8, 1, 0, 0);
      en_step(1, 8, 1, 0, 0);
      // rejected loads, then recovery
      add(1, 2, 0, 5, 0, 0,   3, 0, 0, 1);
      en_step(1, 3, 0, 0, 1);
      add(1, 2, 3, 9, 0, 0,   2, 1, 0, 0);
      en_step(1, 5, 1, 0, 0);
      en_step(0, 5, 1, 0, 0);
      en_step(1, 8, 1, 0, 0);
      en_step(1, 2, 1, 1, 0);
      add(1, 9, 1, 5, 0, 1,   3, 0, 0, 1);
      // reserved mode behaves as WRAP, step at full range
      add(1, 0, 15, 15, 3, 0, 0, 1, 0, 0);
      en_step(1, 15, 1, 0, 0);
      en_step(1, 0, 1, 1, 0);

      repeat (2) @(posedge clk);
      #1 check_outs("reset", int'(INITV), 0, 0, 0);
      @(negedge clk) rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].ld, vecs[i].s, vecs[i].st, vecs[i].lim, vecs[i].md, vecs[i].en);
         @(posedge clk);
         #1 check_outs($sformatf("vec%0d", i), vecs[i].cur, vecs[i].v, vecs[i].w, vecs[i].e);
      end

      // load beats enable in the same cycle, even mid-run
      drive(1, 2, 3, 14, 0, 1);
      @(posedge clk);
      #1 check_outs("ld_en0", 2, 1, 0, 0);
      drive(0, 0, 0, 0, 0, 1);
      @(posedge clk);
      #1 check_outs("ld_en1", 5, 1, 0, 0);
      drive(1, 4, 1, 14, 0, 1);
      @(posedge clk);
      #1 check_outs("ld_en2", 4, 1, 0, 0);
      drive(0, 0, 0, 0, 0, 1);
      @(posedge clk);
      #1 check_outs("ld_en3", 5, 1, 0, 0);

      // asynchronous reset between edges
      #3 rst_n = 1'b0;
      #1 check_outs("async_rst", int'(INITV), 0, 0, 0);
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1 check_outs($sformatf("post_rst%0d", i), int'(INITV), 0, 0, 0);
      end

      // randomized run against the reference model
      model_reset();
      for (int i = 0; i < 600; i++) begin
         bit ld, en;
         int s, st, lim, md;
         ld  = (i == 0) || ($urandom_range(0, 11) == 0);
         s   = $urandom_range(0, 15);
         st  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 15);
         lim = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 15) : $urandom_range(s, 15);
         md  = $urandom_range(0, 3);
         en  = ($urandom_range(0, 3) != 0);
         drive(ld, s, st, lim, md, en);
         @(posedge clk);
         model_step(ld, s, st, lim, md, en);
         #1 check_outs($sformatf("rnd%0d", i), m_cur, (m_state != 0), m_wrap[0], m_err[0]);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/stride_seq_gen.md
STRIDE_SEQ_GEN -- requirements
Module: stride_seq_gen

Interface
REQ-001 Parameter WIDTH, 8, bit width of sequence value and config fields (min 2).
REQ-002 Parameter INIT, 0, value of cur while in IDLE and after reset.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; low forces reset state immediately.
REQ-005 load  input  1  latch start_val/step_val/limit_val/mode and (re)start sequence.
REQ-006 start_val  input  WIDTH  first sequence value.
REQ-007 step_val  input  WIDTH  stride, unsigned.
REQ-008 limit_val  input  WIDTH  upper bound, inclusive.
REQ-009 mode  input  2  0=WRAP, 1=BOUNCE, 2=ONESHOT, 3=reserved (behaves as WRAP).
REQ-010 enable  input  1  advance one step per cycle while high in RUN.
REQ-011 cur  output  WIDTH  current sequence value.
REQ-012 valid  output  1  high in RUN and DONE.
REQ-013 wrap  output  1  one-cycle pulse on each boundary event.
REQ-014 cfg_err  output  1  sticky: last load was rejected.

Function
REQ-015 States IDLE, RUN, DONE; internal dir bit (UP/DOWN) and latched config registers.
REQ-016 load (any state): step_val==0 or start_val>limit_val -> IDLE, cfg_err=1, cur=INIT; else latch config, cur=start_val, dir=UP, cfg_err=0, -> RUN; wrap=0 that cycle.
REQ-017 load has priority over enable in the same cycle.
REQ-018 RUN, enable low: cur, dir, state hold; wrap=0.
REQ-019 Sum cur+step computed in WIDTH+1 bits; "over" = sum > limit (carry out counts as over).
REQ-020 WRAP, not over: cur<=cur+step; over: cur<=start, wrap=1.
REQ-021 ONESHOT, not over: cur<=cur+step; over: cur holds, -> DONE, wrap=1.
REQ-022 BOUNCE UP, not over: cur<=cur+step; over: dir<=DOWN, wrap=1, cur<=(cur>=start+step) ? cur-step : start.
REQ-023 BOUNCE DOWN, cur>=start+step (WIDTH+1-bit compare): cur<=cur-step; else dir<=UP, wrap=1, cur<=(cur+step<=limit) ? cur+step : limit.
REQ-024 DONE: cur holds last value, valid=1, enable ignored; exit only via load.
REQ-025 IDLE: cur=INIT, valid=0, enable ignored.
REQ-026 All outputs registered; cur changes on the edge where enable (or load) is sampled high; latency 1 cycle.

Reset
REQ-027 reset low: state=IDLE, cur=INIT, dir=UP, valid=0, wrap=0, cfg_err=0, config registers=0, asynchronously.
REQ-028 reset asserted mid-RUN abandons sequence; after release block stays IDLE until load.
REQ-029 Reset deassertion is synchronised externally; block needs no internal synchroniser.

Structure
REQ-030 Package stride_seq_pkg holds mode_t (WRAP/BOUNCE/ONESHOT/RSVD), state_t (IDLE/RUN/DONE), dir_t.
REQ-031 One combinational sub-module stride_next computes next cur, next dir, over and wrap from cur, dir, config, mode.
REQ-032 stride_seq_gen holds state/config/cur registers and the load/enable control.

Verification
REQ-033 WIDTH=4, WRAP, start=0 step=2 limit=8, enable held -> cur 0,2,4,6,8,0,2; wrap high only on the cycle cur becomes 0.
REQ-034 WIDTH=4, WRAP, start=10 step=4 limit=15 -> cur 10,14,10 (carry-out treated as over), wrap on the return to 10.
REQ-035 WIDTH=4, BOUNCE, start=1 step=3 limit=8 -> cur 1,4,7,4,1,4,7; wrap pulses on 7->4 and 1->4.
REQ-036 ONESHOT, start=0 step=2 limit=8 -> 0,2,4,6,8, then DONE with cur=8, valid=1, one wrap pulse; further enable holds 8.
REQ-037 load with step_val=0 -> cfg_err=1, valid=0, cur=INIT; then valid load clears cfg_err and runs.
REQ-038 reset low mid-RUN between clock edges -> outputs reset immediately; load with enable high in the same cycle -> cur=start_val, not start_val+step.
